// File: rtl/decode_round_controller.sv
// decode_round_controller: sequences one decoding round across the PE mesh.
// Captures a syndrome, broadcasts it, pulses start_offer, waits for the mesh
// to stay quiet for IDLE_CYCLES cycles, pulses stop_offer, then signals done.
// Optional feature macro: DECODE_TIMEOUT_EN adds an offer-phase watchdog
// (MAX_CYCLES) that forces the round to stop and flags timeout_out.
module decode_round_controller #(
    parameter int unsigned NUM_PE        = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES   = 8,
    parameter int unsigned CYCLE_WIDTH   = 16
`ifdef DECODE_TIMEOUT_EN
    ,
    parameter int unsigned MAX_CYCLES    = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PE-1:0]      meas_value_in,
    input  logic                   meas_valid_in,
    output logic                   meas_ready_out,
    output logic [NUM_PE-1:0]      measurement_value_out,
    output logic                   measurement_valid_out,
    output logic                   start_offer,
    output logic                   stop_offer,
    input  logic [NUM_PE-1:0]      busy_in,
    output logic                   done_out,
    output logic                   busy_out,
    output logic                   timeout_out,
    output logic [CYCLE_WIDTH-1:0] cycle_count_out
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned QUIET_W  = $clog2(IDLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [QUIET_W-1:0]  QUIET_LIMIT = QUIET_W'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_OFFER  = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [QUIET_W-1:0]     quiet_cnt_q, quiet_cnt_d;
    logic [CYCLE_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [NUM_PE-1:0]      meas_vec_q, meas_vec_d;
    logic                   meas_ready_q, meas_ready_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   start_q, start_d;
    logic                   stop_q, stop_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
`ifdef DECODE_TIMEOUT_EN
    logic                   timeout_q, timeout_d;
`endif

    logic                   any_busy;
    logic [SETTLE_W-1:0]    settle_nxt;
    logic [QUIET_W-1:0]     quiet_nxt;
    logic [CYCLE_WIDTH-1:0] cycle_inc;

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        quiet_cnt_d  = quiet_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        meas_vec_d   = meas_vec_q;
        start_d      = 1'b0;
`ifdef DECODE_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif
        any_busy   = |busy_in;
        settle_nxt = settle_cnt_q + 1'b1;
        quiet_nxt  = quiet_cnt_q + 1'b1;
        // cycle_count_out reads as cycles elapsed since start_offer, saturating
        cycle_inc  = (cycle_cnt_q == {CYCLE_WIDTH{1'b1}}) ? cycle_cnt_q
                                                          : cycle_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (meas_valid_in && meas_ready_q) begin
                    meas_vec_d = meas_value_in;
`ifdef DECODE_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d      = S_SETTLE;
                settle_cnt_d = '0;
                start_d      = (SETTLE_LAST == '0);
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d     = S_OFFER;
                    quiet_cnt_d = '0;
                    cycle_cnt_d = CYCLE_WIDTH'(1);
                end else begin
                    settle_cnt_d = settle_nxt;
                    start_d      = (settle_nxt == SETTLE_LAST);
                end
            end
            S_OFFER: begin
                cycle_cnt_d = cycle_inc;
                quiet_cnt_d = any_busy ? '0 : quiet_nxt;
                // quiescence wins over the watchdog when both land together
                if (!any_busy && (quiet_nxt == QUIET_LIMIT)) begin
                    state_d = S_STOP;
                end
`ifdef DECODE_TIMEOUT_EN
                else if (32'(cycle_inc) >= MAX_CYCLES) begin
                    state_d   = S_STOP;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_STOP:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        meas_ready_d = (state_d == S_IDLE);
        meas_valid_d = (state_d == S_LOAD);
        stop_d       = (state_d == S_STOP);
        done_d       = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers, synchronous reset to all-zero outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            quiet_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
            meas_vec_q   <= '0;
            meas_ready_q <= 1'b0;
            meas_valid_q <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef DECODE_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            quiet_cnt_q  <= quiet_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            meas_vec_q   <= meas_vec_d;
            meas_ready_q <= meas_ready_d;
            meas_valid_q <= meas_valid_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
`ifdef DECODE_TIMEOUT_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign meas_ready_out        = meas_ready_q;
    assign measurement_value_out = meas_vec_q;
    assign measurement_valid_out = meas_valid_q;
    assign start_offer           = start_q;
    assign stop_offer            = stop_q;
    assign done_out              = done_q;
    assign busy_out              = busy_q;
    assign cycle_count_out       = cycle_cnt_q;
`ifdef DECODE_TIMEOUT_EN
    assign timeout_out           = timeout_q;
`else
    assign timeout_out           = 1'b0;
`endif

endmodule

// File: doc/decode_round_controller.md
# decode_round_controller

Sequences one decoding round across the PE array: captures a syndrome vector, broadcasts it to every PE for one cycle, pulses `start_offer`, watches array-wide activity until the mesh has been quiet for a programmable number of cycles, then pulses `stop_offer` and signals completion. It sits between the host/syndrome interface and the PE mesh, driving the `measurement_*`, `start_offer` and `stop_offer` inputs that every `pe` instance shares.

## Interface
- `NUM_PE`, 16: number of PEs; width of the syndrome and activity vectors.
- `SETTLE_CYCLES`, 4: cycles between measurement broadcast and `start_offer`; must be at least 1.
- `IDLE_CYCLES`, 8: consecutive all-quiet cycles that end the offer phase; must be at least 1.
- `CYCLE_WIDTH`, 16: width of the offer-phase cycle counter.
- `MAX_CYCLES`, 4096: watchdog limit, used only with `DECODE_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `meas_value_in` in NUM_PE: syndrome bits, one per PE.
- `meas_valid_in` in 1: syndrome valid.
- `meas_ready_out` out 1: controller can accept a syndrome.
- `measurement_value_out` out NUM_PE: per-PE measurement, fanned to each `pe.measurement_value_in`.
- `measurement_valid_out` out 1: broadcast strobe to all PEs.
- `start_offer` out 1: one-cycle pulse to all PEs.
- `stop_offer` out 1: one-cycle pulse to all PEs.
- `busy_in` in NUM_PE: per-PE activity, meaning an outqueue is valid or a mailbox is occupied.
- `done_out` out 1: one-cycle pulse when the round ends.
- `busy_out` out 1: high in every state except IDLE.
- `timeout_out` out 1: the last round was ended by the watchdog.
- `cycle_count_out` out CYCLE_WIDTH: offer-phase length of the last round.

## Operation
- FSM states: IDLE, LOAD, SETTLE, OFFER, STOP, DONE. All outputs are registered.
- IDLE: `meas_ready_out`=1. When `meas_valid_in` and `meas_ready_out` are both high, register `meas_value_in` and go to LOAD.
- LOAD: `measurement_valid_out`=1 with the registered vector for exactly one cycle, then go to SETTLE.
- SETTLE: count `SETTLE_CYCLES` cycles. On the last one, assert `start_offer` for one cycle and go to OFFER.
- OFFER:
  - `cycle_count_out` increments each cycle and saturates at all-ones.
  - The quiet counter clears on any cycle where `|busy_in` is 1 and increments otherwise.
  - When the quiet counter reaches `IDLE_CYCLES`, go to STOP.
- STOP: `stop_offer`=1 for one cycle, then go to DONE.
- DONE: `done_out`=1 for one cycle, then go to IDLE.
- `measurement_value_out` holds its value after LOAD until the next capture.
- `cycle_count_out` clears on entry to OFFER and holds after the round ends.
- `timeout_out` clears on the next capture.

## Timing
- Reset value of every output is 0, including `meas_ready_out` while `reset` is high. `meas_ready_out` rises on the first cycle after `reset` is deasserted.
- Capture to `measurement_valid_out`: 1 cycle.
- `measurement_valid_out` to `start_offer`: `SETTLE_CYCLES` cycles.
- The earliest `stop_offer` comes `IDLE_CYCLES`+1 cycles after `start_offer`, when `busy_in` is constantly 0.
- `done_out` comes 1 cycle after `stop_offer`. `meas_ready_out` rises the cycle after `done_out`.
- `busy_in` is ignored outside OFFER.
- `meas_valid_in` is ignored outside IDLE; there is no queueing.
- A `busy_in` bit high on the same cycle the quiet counter would reach threshold clears the counter; the round does not end on that cycle.
- `reset` asserted mid-round: on the next edge the FSM returns to IDLE and all outputs go to 0. No `stop_offer` or `done_out` is emitted.
- The quiet counter is `$clog2(IDLE_CYCLES+1)` bits and never wraps.

## Configuration
- `DECODE_TIMEOUT_EN` defined: in OFFER, when `cycle_count_out` reaches `MAX_CYCLES`, the FSM goes to STOP regardless of activity and sets `timeout_out`=1 until the next capture. Quiescence and timeout on the same cycle count as quiescence, with `timeout_out`=0.
- `DECODE_TIMEOUT_EN` undefined: no watchdog logic; `timeout_out` is tied to 0 and OFFER exits only on quiescence.

## Test plan
Benches use `NUM_PE`=4, `SETTLE_CYCLES`=4, `IDLE_CYCLES`=8.
- Quiet array: capture `meas_value_in`=4'b0101 with `busy_in`=0. Required:
  - `measurement_valid_out` pulses 1 cycle later with value 4'b0101.
  - `start_offer` pulses 4 cycles after that.
  - `stop_offer` pulses 9 cycles after `start_offer`, then `done_out` follows.
  - `cycle_count_out`=9.
- Activity extends the round: hold `busy_in`=4'b0010 for 20 cycles after `start_offer`. Required: `stop_offer` exactly 8 quiet cycles after `busy_in` drops; `cycle_count_out`=29.
- Threshold collision: pulse `busy_in`=4'b1000 on the cycle the quiet count would reach 8. Required: no stop on that cycle; stop 8 cycles later.
- Back-pressure: hold `meas_valid_in`=1 throughout the round. Required: `meas_ready_out`=0 from capture through DONE; a second capture happens the cycle after `done_out`.
- Reset mid-OFFER: assert `reset` for 1 cycle. Required: all outputs 0 next cycle, no `done_out`, `meas_ready_out`=1 on the following cycle.
- With `DECODE_TIMEOUT_EN` and `MAX_CYCLES`=50: hold `busy_in`=4'b1111. Required: `stop_offer` at offer cycle 50, `timeout_out`=1, `cycle_count_out`=50.
